// File: rtl/ascon_round_engine_if.sv
// Start/done handshake bundle between a mode controller and the Ascon permutation engine.
// Latency: none, wires only; the engine registers all of its outputs.
// Backpressure: none; start_i is only honoured while busy_o is low, so requests made while busy are dropped.
//
// Signals:
//   start_i  - request a permutation (controller -> engine)
//   rounds_i - round count, 0..16 (larger values clamp to 16)
//   state_i  - 320-bit input state, words 0..4 (word w at [w])
//   state_o  - registered permutation state (engine -> controller)
//   busy_o   - rounds in progress
//   done_o   - one-cycle pulse, state_o holds the result
interface ascon_round_engine_if;
  logic                 start_i;
  logic [4:0]           rounds_i;
  logic [4:0][63:0]     state_i;
  logic [4:0][63:0]     state_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i,
    output rounds_i,
    output state_i,
    input  state_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  rounds_i,
    input  state_i,
    output state_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/ascon_round_engine.sv
// Iterative Ascon-p permutation: one full round (constant, S-box, linear) per clock.
// Latency: rnd + 1 cycles from accepted start to done_o (1 cycle for rnd = 0).
// Backpressure: start_i is ignored while busy_o is high (no queuing); it is accepted in IDLE and DONE.
//
// Contents: ascon_pkg (shared widths and the state type), substitution_layer (5-bit
// S-box applied to all 64 bit columns) and the top ascon_round_engine.
//
// Ports of ascon_round_engine:
//   clk_i - clock, all state updates on its rising edge
//   rst_i - synchronous active-high reset, aborts any job in flight
//   bus   - ascon_round_engine_if.slave (start/rounds/state in, state/busy/done out)

package ascon_pkg;
  localparam int NUM_WORDS  = 5;
  localparam int WORD_WIDTH = 64;

  // Word w of the state lives at index [w]; word 0 is x0 in Ascon notation.
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
endpackage

// Ascon 5-bit S-box applied to every bit column of the state.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   state_i - state after constant addition
//   state_o - state after substitution
module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  logic [4:0] col_in;
  logic [4:0] col_out;

  always_comb begin
    state_o = '0;
    col_in  = '0;
    col_out = '0;
    for (int j = 0; j < WORD_WIDTH; j++) begin
      // Word 0 supplies the MSB of the column index.
      col_in        = {state_i[0][j], state_i[1][j], state_i[2][j], state_i[3][j], state_i[4][j]};
      col_out       = sbox(col_in);
      state_o[0][j] = col_out[4];
      state_o[1][j] = col_out[3];
      state_o[2][j] = col_out[2];
      state_o[3][j] = col_out[1];
      state_o[4][j] = col_out[0];
    end
  end

endmodule

// Shared Ascon-p permutation core for the AEAD, hash and XOF controllers.
// Latency: rnd + 1 cycles, one round per cycle, no pipelining inside a round.
// Backpressure: a single job at a time; start_i while busy_o is high is dropped.
module ascon_round_engine
  import ascon_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  ascon_round_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q;
  ascon_state_t state_q;
  logic [3:0]   k_q;
  logic         busy_q;
  logic         done_q;

  // Round count handling: clamp first, then derive the first constant index.
  logic [4:0]   rnd_clamped;
  logic [3:0]   k_start;
  logic         rnd_zero;

  // Round datapath.
  logic [3:0]   rc_low;
  logic [7:0]   rc_byte;
  ascon_state_t const_added;
  ascon_state_t sub_out;
  ascon_state_t lin_out;

  assign rnd_clamped = (bus.rounds_i > 5'd16) ? 5'd16 : bus.rounds_i;
  assign rnd_zero    = (rnd_clamped == 5'd0);
  // 16 - rnd taken in 5 bits and truncated to 4 is the 4-bit negation of rnd;
  // rnd = 16 therefore starts at k = 0.
  assign k_start     = 4'd0 - rnd_clamped[3:0];

  // Constant byte {~r, r} with r = (k + 12) mod 16: k = 0 -> 0x3c, k = 15 -> 0x4b.
  assign rc_low  = k_q + 4'd12;
  assign rc_byte = {~rc_low, rc_low};

  always_comb begin
    const_added       = state_q;
    const_added[2]    = {state_q[2][63:8], state_q[2][7:0] ^ rc_byte};
  end

  substitution_layer u_substitution_layer (
    .state_i (const_added),
    .state_o (sub_out)
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    lin_out    = '0;
    lin_out[0] = sub_out[0] ^ rotr(sub_out[0], 19) ^ rotr(sub_out[0], 28);
    lin_out[1] = sub_out[1] ^ rotr(sub_out[1], 61) ^ rotr(sub_out[1], 39);
    lin_out[2] = sub_out[2] ^ rotr(sub_out[2],  1) ^ rotr(sub_out[2],  6);
    lin_out[3] = sub_out[3] ^ rotr(sub_out[3], 10) ^ rotr(sub_out[3], 17);
    lin_out[4] = sub_out[4] ^ rotr(sub_out[4],  7) ^ rotr(sub_out[4], 41);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      k_q     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (fsm_q)
        // DONE accepts a new start exactly like IDLE so jobs can run back to back.
        IDLE, DONE: begin
          done_q <= 1'b0;
          fsm_q  <= IDLE;
          if (bus.start_i) begin
            state_q <= bus.state_i;
            k_q     <= k_start;
            if (rnd_zero) begin
              fsm_q  <= DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end

        RUN: begin
          state_q <= lin_out;
          // k = 15 is always the final round, so k never wraps inside a job.
          if (k_q == 4'd15) begin
            fsm_q  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end

        default: begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_o = state_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ascon_round_engine.sv
// Self-checking bench for ascon_round_engine: reset, single rounds, Hash256 IV,
// start while busy, round-count boundaries, back-to-back jobs and reset abort.
module tb_ascon_round_engine;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_round_engine_if bus ();

  ascon_round_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int  total = 0;
  int  bad   = 0;
  st_t exp_q[$];

  // ---------------- reference model (bitsliced, table-driven constants) ----------------
  function automatic logic [7:0] rc(input int k);
    logic [7:0] c;
    case (k)
      0: c = 8'h3c;  1: c = 8'h2d;  2: c = 8'h1e;  3: c = 8'h0f;
      4: c = 8'hf0;  5: c = 8'he1;  6: c = 8'hd2;  7: c = 8'hc3;
      8: c = 8'hb4;  9: c = 8'ha5; 10: c = 8'h96; 11: c = 8'h87;
     12: c = 8'h78; 13: c = 8'h69; 14: c = 8'h5a; 15: c = 8'h4b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic st_t lin_m(input st_t s);
    st_t o;
    o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    o[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    return o;
  endfunction

  function automatic st_t sbox_m(input st_t s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    st_t o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic st_t round_m(input st_t s, input int k);
    st_t t;
    t = s;
    t[2][7:0] = t[2][7:0] ^ rc(k);
    return lin_m(sbox_m(t));
  endfunction

  function automatic st_t perm_m(input st_t s, input int rnd);
    st_t t;
    int  r;
    t = s;
    r = (rnd > 16) ? 16 : rnd;
    for (int k = 16 - r; k < 16; k++) t = round_m(t, k);
    return t;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle (edge 0); optionally records the expected result.
  task automatic launch(input st_t s, input logic [4:0] r, input bit push);
    bus.start_i  = 1'b1;
    bus.state_i  = s;
    bus.rounds_i = r;
    if (push) exp_q.push_back(perm_m(s, int'(r)));
    tick();
    bus.start_i = 1'b0;
  endtask

  // Counts edges (the start edge is edge 1 of the count) until done_o; -1 on timeout.
  task automatic wait_done(output int n);
    n = 1;
    while (bus.done_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.done_o !== 1'b1) n = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int  n;
    st_t e;
    rst          = 1'b1;
    bus.start_i  = 1'b1;
    bus.state_i  = rand_st();
    bus.rounds_i = 5'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.state_o !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: busy=%b done=%b state=%h, want 0/0/0",
                 i, bus.busy_o, bus.done_o, bus.state_o);
      end
    end
    rst = 1'b0;
    launch(bus.state_i, 5'd3, 1'b1);
    total++;
    if (bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_start: busy=%b want 1", bus.busy_o);
    end
    wait_done(n);
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL reset_job_latency: got %0d want 4", n);
    end
    e = exp_q.pop_front();
    total++;
    if (bus.state_o !== e) begin
      bad++;
      $display("FAIL reset_job_result: got %h want %h", bus.state_o, e);
    end
  endtask

  task automatic test_rnd1();
    int  n;
    st_t after_s;
    st_t e;
    after_s[0] = 64'h4b;
    after_s[1] = 64'h4b;
    after_s[2] = 64'hffffffffffffffb4;
    after_s[3] = 64'h4b;
    after_s[4] = 64'h0;
    launch('0, 5'd1, 1'b1);
    total++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL rnd1_edge0: done=%b busy=%b want 0/1", bus.done_o, bus.busy_o);
    end
    wait_done(n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL rnd1_latency: got %0d want 2", n);
    end
    total++;
    if (bus.state_o !== lin_m(after_s)) begin
      bad++;
      $display("FAIL rnd1_linear_of_sbox: got %h want %h", bus.state_o, lin_m(after_s));
    end
    e = exp_q.pop_front();
    total++;
    if (bus.state_o !== e) begin
      bad++;
      $display("FAIL rnd1_model: got %h want %h", bus.state_o, e);
    end
  endtask

  task automatic test_hash_iv();
    int  n;
    st_t iv, gold, e;
    iv      = '0;
    iv[0]   = 64'h0000080100cc0002;
    gold[0] = 64'h9b1e5494e934d681;
    gold[1] = 64'h4bc3a01e333751d2;
    gold[2] = 64'hae65396c6b34b81a;
    gold[3] = 64'h3c7fd4a4d56a4db3;
    gold[4] = 64'h1a5c464906c5976d;
    launch(iv, 5'd12, 1'b1);
    wait_done(n);
    total++;
    if (n != 13) begin
      bad++;
      $display("FAIL hash_iv_latency: got %0d want 13", n);
    end
    total++;
    if (bus.state_o !== gold) begin
      bad++;
      $display("FAIL hash_iv_value: got %h want %h", bus.state_o, gold);
    end
    e = exp_q.pop_front();
    total++;
    if (bus.state_o !== e) begin
      bad++;
      $display("FAIL hash_iv_model: got %h want %h", bus.state_o, e);
    end
  endtask

  task automatic test_start_busy();
    int  early = 0, dcnt = 0, dedge = -1;
    st_t e;
    launch(rand_st(), 5'd8, 1'b1);
    bus.state_i = rand_st();
    for (int ed = 1; ed <= 12; ed++) begin
      bus.start_i = (ed == 3 || ed == 5);
      tick();
      if (ed < 8 && bus.busy_o !== 1'b1) early++;
      if (bus.done_o === 1'b1) begin
        dcnt++;
        if (dedge < 0) begin
          dedge = ed;
          e = exp_q.pop_front();
          total++;
          if (bus.state_o !== e) begin
            bad++;
            $display("FAIL busy_start_result: got %h want %h", bus.state_o, e);
          end
        end
      end
    end
    bus.start_i = 1'b0;
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL busy_start_busy_drop: %0d early low cycles, want 0", early);
    end
    total++;
    if (dcnt != 1 || dedge != 8) begin
      bad++;
      $display("FAIL busy_start_done: count=%0d edge=%0d want 1 at edge 8", dcnt, dedge);
    end
  endtask

  task automatic test_rounds_bounds();
    int  n;
    st_t s, e;
    s = rand_st();
    launch(s, 5'd0, 1'b1);
    wait_done(n);
    total++;
    if (n != 1 || bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rnd0_timing: latency=%0d busy=%b want 1/0", n, bus.busy_o);
    end
    e = exp_q.pop_front();
    total++;
    if (bus.state_o !== s || bus.state_o !== e) begin
      bad++;
      $display("FAIL rnd0_identity: got %h want %h", bus.state_o, s);
    end
    tick();
    total++;
    if (bus.done_o !== 1'b0) begin
      bad++;
      $display("FAIL rnd0_pulse_width: done=%b want 0", bus.done_o);
    end

    s = rand_st();
    launch(s, 5'd16, 1'b1);
    wait_done(n);
    e = exp_q.pop_front();
    total++;
    if (n != 17 || bus.state_o !== e) begin
      bad++;
      $display("FAIL rnd16: latency=%0d state=%h want 17 and %h", n, bus.state_o, e);
    end

    launch(s, 5'd20, 1'b1);
    tick();
    total++;
    if (bus.state_o !== round_m(s, 0)) begin
      bad++;
      $display("FAIL rnd20_first_const: got %h want %h", bus.state_o, round_m(s, 0));
    end
    wait_done(n);
    e = exp_q.pop_front();
    total++;
    if (n + 1 != 17 || bus.state_o !== perm_m(s, 16) || bus.state_o !== e) begin
      bad++;
      $display("FAIL rnd20_clamp: latency=%0d state=%h want 17 and %h", n + 1, bus.state_o, e);
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    st_t a, b, e;
    a = rand_st();
    b = rand_st();
    bus.start_i  = 1'b1;
    bus.state_i  = a;
    bus.rounds_i = 5'd6;
    exp_q.push_back(perm_m(a, 6));
    tick();
    bus.state_i = b;
    exp_q.push_back(perm_m(b, 6));
    wait_done(n);
    e = exp_q.pop_front();
    total++;
    if (n != 7 || bus.state_o !== e) begin
      bad++;
      $display("FAIL b2b_first: latency=%0d state=%h want 7 and %h", n, bus.state_o, e);
    end
    tick();
    bus.start_i = 1'b0;
    total++;
    if (bus.busy_o !== 1'b1 || bus.state_o !== b) begin
      bad++;
      $display("FAIL b2b_load_in_done: busy=%b state=%h want 1 and %h", bus.busy_o, bus.state_o, b);
    end
    wait_done(n);
    e = exp_q.pop_front();
    total++;
    if (n != 7 || bus.state_o !== e) begin
      bad++;
      $display("FAIL b2b_second: latency=%0d state=%h want 7 and %h", n, bus.state_o, e);
    end
    tick();
  endtask

  task automatic test_abort();
    int  n, dseen = 0;
    st_t e;
    launch(rand_st(), 5'd12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done_o === 1'b1) dseen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.state_o !== '0) begin
      bad++;
      $display("FAIL abort_cleared: busy=%b done=%b state=%h want 0/0/0",
               bus.busy_o, bus.done_o, bus.state_o);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done_o === 1'b1) dseen++;
    end
    total++;
    if (dseen != 0) begin
      bad++;
      $display("FAIL abort_no_done: saw %0d pulses want 0", dseen);
    end
    launch(rand_st(), 5'd12, 1'b1);
    wait_done(n);
    e = exp_q.pop_front();
    total++;
    if (n != 13 || bus.state_o !== e) begin
      bad++;
      $display("FAIL abort_restart: latency=%0d state=%h want 13 and %h", n, bus.state_o, e);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.rounds_i = 5'd0;
    bus.state_i  = '0;
    test_reset();
    test_rnd1();
    test_hash_iv();
    test_start_busy();
    test_rounds_bounds();
    test_back_to_back();
    test_abort();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
